// File: rtl/lsu_if.sv
// lsu_if: bundles the LSU request, data-RAM bus and write-back signals.
// Latency: none, wiring only.
// Backpressure: req_ready/stall_o flow back to the EX stage; bus_ack paces the RAM side.
// Ports: slave = LSU view; master = pipeline + data RAM view.
interface lsu_if #(
  parameter int ADDR_W = 32
);
  // EX-stage request
  logic              req_valid;
  logic              req_ready;
  logic              stall_o;
  logic [3:0]        op;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       data_i;
  logic              wreg_en;
  logic [4:0]        wreg_idx;

  // data-RAM bus
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [31:0]       bus_wdata;
  logic              bus_ack;
  logic [31:0]       bus_rdata;

  // write-back result and exception flags
  logic              resp_valid;
  logic              wb_en;
  logic [4:0]        wb_idx;
  logic [31:0]       wb_data;
  logic              exc_misalign;
  logic              bus_err;

  modport slave (
    input  req_valid, op, addr, data_i, wreg_en, wreg_idx, bus_ack, bus_rdata,
    output req_ready, stall_o, bus_req, bus_we, bus_addr, bus_be, bus_wdata,
           resp_valid, wb_en, wb_idx, wb_data, exc_misalign, bus_err
  );

  modport master (
    output req_valid, op, addr, data_i, wreg_en, wreg_idx, bus_ack, bus_rdata,
    input  req_ready, stall_o, bus_req, bus_we, bus_addr, bus_be, bus_wdata,
           resp_valid, wb_en, wb_idx, wb_data, exc_misalign, bus_err
  );
endinterface

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit between the EX stage and the data RAM.
// Latency: NOP/misalign trap 1 cycle accept->resp_valid; memory op 2 cycles plus bus wait states.
// Backpressure: req_ready only in IDLE; stall_o = req_valid & ~req_ready while an op is in flight.
// Ports: clk, rst (async active-low); io (lsu_if.slave) carries request, RAM bus and write-back.
// Params: ADDR_W address width; TIMEOUT max unacknowledged BUS cycles (1..255).
// Option: define LSU_MISALIGN_EXC_EN to trap misaligned half/word accesses; otherwise they are aligned down.
module lsu #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic  clk,
  input logic  rst,
  lsu_if.slave io
);

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Request fields captured on accept; everything downstream works off this copy.
  typedef struct packed {
    logic [3:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       dat;
    logic              wreg_en;
    logic [4:0]        wreg_idx;
  } req_t;

  // Access size in bytes; 0 means the op is not a memory access (NOP pass-through).
  function automatic logic [2:0] op_size(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_size = 3'd1;
      OP_LH, OP_LHU, OP_SH: op_size = 3'd2;
      OP_LW, OP_SW:         op_size = 3'd4;
      default:              op_size = 3'd0;
    endcase
  endfunction

  function automatic logic op_store(input logic [3:0] op);
    op_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic op_signed(input logic [3:0] op);
    op_signed = (op == OP_LB) || (op == OP_LH);
  endfunction

  state_t      state_q, state_d;
  req_t        req_q;
  logic [7:0]  wait_q;
  logic [7:0]  wait_inc;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        mis_q;

  logic        accept;
  logic [2:0]  new_size;
  logic        new_mem;
  logic        new_mis;
  logic        timeout_hit;

  logic [2:0]  cur_size;
  logic        cur_store;
  logic        cur_signed;
  logic [1:0]  byte_ofs;
  logic [31:0] lane;
  logic [31:0] load_val;
  logic [3:0]  be;
  logic [31:0] wdata;

  assign accept   = io.req_valid && (state_q == S_IDLE);
  assign new_size = op_size(io.op);
  assign new_mem  = (new_size != 3'd0);

`ifdef LSU_MISALIGN_EXC_EN
  assign new_mis = ((new_size == 3'd2) && io.addr[0]) ||
                   ((new_size == 3'd4) && (io.addr[1:0] != 2'b00));
  assign io.exc_misalign = (state_q == S_RESP) && mis_q;
`else
  // Misaligned half/word accesses are aligned down by the lane logic below.
  assign new_mis = 1'b0;
  assign io.exc_misalign = 1'b0;
`endif

  assign io.stall_o = io.req_valid && !io.req_ready;

  // Ack takes priority: a timeout only fires on a cycle with no ack.
  assign wait_inc    = wait_q + 8'd1;
  assign timeout_hit = (state_q == S_BUS) && !io.bus_ack && (wait_inc == TMO);

  assign cur_size   = op_size(req_q.op);
  assign cur_store  = op_store(req_q.op);
  assign cur_signed = op_signed(req_q.op);

  // Byte lane of the access; half ignores addr[0] and word ignores addr[1:0].
  always_comb begin
    byte_ofs = 2'b00;
    case (cur_size)
      3'd1:    byte_ofs = req_q.addr[1:0];
      3'd2:    byte_ofs = {req_q.addr[1], 1'b0};
      default: byte_ofs = 2'b00;
    endcase
  end

  // Little-endian: lane 0 is rdata[7:0].
  assign lane = rdata_q >> {byte_ofs, 3'b000};

  always_comb begin
    load_val = lane;
    case (cur_size)
      3'd1:    load_val = {{24{cur_signed & lane[7]}}, lane[7:0]};
      3'd2:    load_val = {{16{cur_signed & lane[15]}}, lane[15:0]};
      default: load_val = lane;
    endcase
  end

  // Stores replicate the datum across every lane so the byte enables alone pick the target.
  always_comb begin
    be    = 4'b0000;
    wdata = 32'h0;
    case (cur_size)
      3'd1: begin
        be    = 4'b0001 << byte_ofs;
        wdata = {4{req_q.dat[7:0]}};
      end
      3'd2: begin
        be    = byte_ofs[1] ? 4'b1100 : 4'b0011;
        wdata = {2{req_q.dat[15:0]}};
      end
      3'd4: begin
        be    = 4'b1111;
        wdata = req_q.dat;
      end
      default: begin
        be    = 4'b0000;
        wdata = 32'h0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and all outputs; every output is gated by state so reset forces them low.
  always_comb begin
    state_d       = state_q;
    io.req_ready  = 1'b0;
    io.bus_req    = 1'b0;
    io.bus_we     = 1'b0;
    io.bus_addr   = '0;
    io.bus_be     = 4'b0000;
    io.bus_wdata  = 32'h0;
    io.resp_valid = 1'b0;
    io.wb_en      = 1'b0;
    io.wb_idx     = 5'd0;
    io.wb_data    = 32'h0;
    io.bus_err    = 1'b0;

    case (state_q)
      S_IDLE: begin
        io.req_ready = 1'b1;
        if (accept) begin
          state_d = (new_mem && !new_mis) ? S_BUS : S_RESP;
        end
      end

      S_BUS: begin
        io.bus_req   = 1'b1;
        io.bus_we    = cur_store;
        io.bus_addr  = {req_q.addr[ADDR_W-1:2], 2'b00};
        io.bus_be    = be;
        io.bus_wdata = cur_store ? wdata : 32'h0;
        if (io.bus_ack || timeout_hit) begin
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        io.resp_valid = 1'b1;
        io.bus_err    = err_q;
        io.wb_idx     = req_q.wreg_idx;
        if (cur_size == 3'd0) begin
          io.wb_en   = req_q.wreg_en;
          io.wb_data = req_q.dat;
        end else if (!cur_store && !err_q && !mis_q) begin
          io.wb_en   = req_q.wreg_en;
          io.wb_data = load_val;
        end
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Request capture, wait counter and read-data capture. bus_ack is only looked at in BUS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q   <= '0;
      wait_q  <= 8'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      if (accept) begin
        req_q.op       <= io.op;
        req_q.addr     <= io.addr;
        req_q.dat      <= io.data_i;
        req_q.wreg_en  <= io.wreg_en;
        req_q.wreg_idx <= io.wreg_idx;
        wait_q         <= 8'd0;
        err_q          <= 1'b0;
        mis_q          <= new_mis;
      end
      if (state_q == S_BUS) begin
        if (io.bus_ack) begin
          rdata_q <= io.bus_rdata;
        end else begin
          wait_q <= wait_inc;
          if (wait_inc == TMO) begin
            err_q <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: randomized scoreboard bench for lsu with a byte-level reference model.
// Latency: driver issues one op at a time and waits out its bus phase and response.
// Backpressure: holds req_valid during a busy cycle to observe stall_o / req_ready.
module tb_lsu;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lsu_if #(.ADDR_W(32)) io();

  lsu #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    int          cycles;
  } bus_exp_t;

  typedef struct {
    logic        wb_en;
    logic        chk_data;
    logic [4:0]  idx;
    logic [31:0] data;
    logic        exc;
    logic        err;
    int          lat;
  } resp_exp_t;

  bus_exp_t  exp_bus_q[$];
  resp_exp_t exp_resp_q[$];
  int        acc_q[$];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit mon_off = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // Monitor: pairs DUT bus activity and responses with the queued expectations.
  bus_exp_t cur_bus;
  int       bus_cnt  = 0;
  logic     bus_prev = 1'b0;
  bit       bus_open = 1'b0;

  always @(negedge clk) begin : mon
    resp_exp_t r;
    int lat;
    if (!mon_off && rst) begin
      if (io.req_valid && io.req_ready) acc_q.push_back(cyc);
      if (io.bus_req) begin
        if (!bus_prev) begin
          bus_cnt = 0;
          if (exp_bus_q.size() == 0) begin
            chk1("unexpected bus_req", io.bus_req, 1'b0);
            bus_open = 1'b0;
          end else begin
            cur_bus  = exp_bus_q.pop_front();
            bus_open = 1'b1;
          end
        end
        bus_cnt++;
        if (bus_open) begin
          chk("bus_addr", io.bus_addr, cur_bus.addr);
          chk("bus_be", 32'(io.bus_be), 32'(cur_bus.be));
          chk1("bus_we", io.bus_we, cur_bus.we);
          if (cur_bus.we) chk("bus_wdata", io.bus_wdata, cur_bus.wdata);
        end
      end else if (bus_prev && bus_open) begin
        chk("bus_req cycles", bus_cnt, cur_bus.cycles);
        bus_open = 1'b0;
      end
      if (io.resp_valid) begin
        if (exp_resp_q.size() == 0) begin
          chk1("unexpected resp_valid", io.resp_valid, 1'b0);
        end else begin
          r   = exp_resp_q.pop_front();
          lat = (acc_q.size() != 0) ? cyc - acc_q.pop_front() : -1;
          chk("resp latency", lat, r.lat);
          chk1("wb_en", io.wb_en, r.wb_en);
          chk1("exc_misalign", io.exc_misalign, r.exc);
          chk1("bus_err", io.bus_err, r.err);
          if (r.wb_en) chk("wb_idx", 32'(io.wb_idx), 32'(r.idx));
          if (r.chk_data) chk("wb_data", io.wb_data, r.data);
        end
      end
    end
    bus_prev = io.bus_req;
  end

  // Issue one op: build expectations from byte-level rules, then drive request and RAM side.
  // dly = BUS cycle index in which bus_ack is raised; negative = never ack (timeout).
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic wen, input logic [4:0] idx, input logic [31:0] rd,
                       input int dly);
    int          sz;
    int          lanes;
    bit          st, sg, mis, err, has_bus;
    logic [31:0] ea, mask, v;
    bus_exp_t    b;
    resp_exp_t   r;

    sz = 0; st = 0; sg = 0; has_bus = 0; err = 0;
    case (op)
      4'd1: begin sz = 1; sg = 1; end
      4'd2: sz = 1;
      4'd3: begin sz = 2; sg = 1; end
      4'd4: sz = 2;
      4'd5: sz = 4;
      4'd6: begin sz = 1; st = 1; end
      4'd7: begin sz = 2; st = 1; end
      4'd8: begin sz = 4; st = 1; end
      default: sz = 0;
    endcase

    r.wb_en = 1'b0; r.chk_data = 1'b0; r.idx = idx; r.data = 32'h0;
    r.exc = 1'b0; r.err = 1'b0; r.lat = 1;

    if (sz == 0) begin
      r.wb_en = wen; r.chk_data = 1'b1; r.data = d;
    end else begin
      mis = (a % sz) != 0;
`ifdef LSU_MISALIGN_EXC_EN
      if (mis) r.exc = 1'b1;
      else has_bus = 1;
`else
      has_bus = 1;
`endif
    end

    if (has_bus) begin
      ea      = a - (a % sz);
      err     = (dly < 0);
      lanes   = ((1 << sz) - 1) << (ea % 4);
      b.addr  = ea & ~32'h3;
      b.be    = lanes[3:0];
      b.we    = st;
      b.wdata = (sz == 1) ? {24'h0, d[7:0]} * 32'h0101_0101 :
                (sz == 2) ? {16'h0, d[15:0]} * 32'h0001_0001 : d;
      b.cycles = err ? TO : dly + 1;
      r.lat    = err ? TO + 1 : dly + 2;
      r.err    = err;
      if (!st && !err) begin
        mask = (sz == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 32'd1;
        v    = (rd >> (8 * (ea % 4))) & mask;
        if (sg && v[8*sz-1]) v = v | ~mask;
        r.wb_en = wen; r.chk_data = 1'b1; r.data = v;
      end
      exp_bus_q.push_back(b);
    end
    exp_resp_q.push_back(r);

    io.req_valid = 1'b1; io.op = op; io.addr = a; io.data_i = d;
    io.wreg_en = wen; io.wreg_idx = idx;
    @(posedge clk); #1;
    // Scramble inputs so a design that fails to register them shows up.
    io.req_valid = 1'b0; io.op = 4'($urandom); io.addr = $urandom;
    io.data_i = $urandom; io.wreg_en = 1'($urandom); io.wreg_idx = 5'($urandom);

    if (has_bus) begin
      for (int k = 0; k < TO; k++) begin
        io.bus_ack   = (k == dly);
        io.bus_rdata = (k == dly) ? rd : $urandom;
        if (k == 0) begin
          io.req_valid = 1'b1;
          @(negedge clk);
          chk1("stall_o while busy", io.stall_o, 1'b1);
          chk1("req_ready while busy", io.req_ready, 1'b0);
        end
        @(posedge clk); #1;
        io.req_valid = 1'b0;
        if (k == dly) break;
      end
      io.bus_ack = 1'b0;
    end

    // Response cycle and following idle cycle: stray acks here must be ignored.
    io.bus_ack = 1'b1; io.bus_rdata = $urandom;
    @(posedge clk); #1;
    io.bus_ack = 1'($urandom); io.bus_rdata = $urandom;
  endtask

  initial begin
    io.req_valid = 1'b1; io.op = 4'd5; io.addr = 32'h0; io.data_i = 32'h0;
    io.wreg_en = 1'b1; io.wreg_idx = 5'd3; io.bus_ack = 1'b1; io.bus_rdata = 32'hFFFF_FFFF;
    rst = 1'b0;
    #12;
    chk1("reset req_ready", io.req_ready, 1'b1);
    chk1("reset stall_o", io.stall_o, 1'b0);
    chk1("reset bus_req", io.bus_req, 1'b0);
    chk1("reset resp_valid", io.resp_valid, 1'b0);
    chk1("reset wb_en", io.wb_en, 1'b0);
    chk("reset wb_data", io.wb_data, 32'h0);
    chk1("reset exc_misalign", io.exc_misalign, 1'b0);
    chk1("reset bus_err", io.bus_err, 1'b0);
    io.req_valid = 1'b0; io.bus_ack = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    do_op(4'd0,  32'h0000_0000, 32'h1234_5678, 1'b1, 5'd9, 32'h0, 0);
    do_op(4'd1,  32'h0000_1003, 32'h0,         1'b1, 5'd5, 32'h80FF_1234, 0);
    do_op(4'd7,  32'h0000_2002, 32'h0000_BEEF, 1'b0, 5'd0, 32'h0, 1);
    do_op(4'd5,  32'h0000_3000, 32'h0,         1'b1, 5'd7, 32'h0, -1);
    do_op(4'd3,  32'h0000_0001, 32'h0,         1'b1, 5'd4, 32'hA5C3_8001, 0);
    do_op(4'd5,  32'h0000_4004, 32'h0,         1'b1, 5'd2, 32'hDEAD_BEEF, TO - 1);
    do_op(4'd2,  32'h0000_5002, 32'h0,         1'b1, 5'd1, 32'h00C3_0000, 0);
    do_op(4'd4,  32'h0000_5002, 32'h0,         1'b1, 5'd1, 32'h9ABC_0000, 2);
    do_op(4'd6,  32'h0000_6001, 32'h0000_0077, 1'b0, 5'd0, 32'h0, 0);
    do_op(4'd8,  32'h0000_7000, 32'hCAFE_F00D, 1'b0, 5'd0, 32'h0, 0);
    do_op(4'd12, 32'h0000_8000, 32'h5555_AAAA, 1'b1, 5'd31, 32'h0, 0);

    for (int i = 0; i < 80; i++) begin
      int dly;
      dly = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TO - 1));
      do_op(4'($urandom_range(0, 15)), $urandom, $urandom, 1'($urandom),
            5'($urandom), $urandom, dly);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("resp queue drained", exp_resp_q.size(), 0);
    chk("bus queue drained", exp_bus_q.size(), 0);

    // Reset while a load waits for ack: bus_req must drop at once and no response may follow.
    mon_off = 1'b1;
    io.bus_ack = 1'b0;
    io.req_valid = 1'b1; io.op = 4'd5; io.addr = 32'h40; io.wreg_en = 1'b1; io.wreg_idx = 5'd3;
    @(posedge clk); #1;
    io.req_valid = 1'b0;
    chk1("bus_req before reset", io.bus_req, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk1("bus_req in reset", io.bus_req, 1'b0);
    chk1("req_ready in reset", io.req_ready, 1'b1);
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk1("resp_valid after abort", io.resp_valid, 1'b0);
      chk1("bus_req after abort", io.bus_req, 1'b0);
    end
    chk1("req_ready after abort", io.req_ready, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter ADDR_W, default 32: bus and request address width.
REQ-002 Parameter TIMEOUT, default 16: maximum BUS-state cycles without bus_ack before abort; legal range 1..255.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous assert, active-low; synchronous deassert is external.
REQ-005 req_valid  in  1  operation present from the EX stage.
REQ-006 req_ready  out  1  stage can accept; stall_o = req_valid & ~req_ready.
REQ-007 stall_o  out  1  pipeline stall to upstream stages.
REQ-008 op  in  4  0=NOP(pass), 1=LB, 2=LBU, 3=LH, 4=LHU, 5=LW, 6=SB, 7=SH, 8=SW; others are treated as NOP.
REQ-009 addr  in  ADDR_W  effective address.
REQ-010 data_i  in  32  store data, or the ALU result for NOP.
REQ-011 wreg_en / wreg_idx  in  1 / 5  destination register request.
REQ-012 bus_req, bus_we  out  1 each  data-RAM request and write strobe.
REQ-013 bus_addr  out  ADDR_W  word-aligned address (bits[1:0]=0).
REQ-014 bus_be, bus_wdata  out  4 / 32  byte enables and write data.
REQ-015 bus_ack, bus_rdata  in  1 / 32  completion strobe and read data.
REQ-016 resp_valid, wb_en, wb_idx, wb_data  out  1/1/5/32  write-back result.
REQ-017 exc_misalign, bus_err  out  1 each  exception flags, valid with resp_valid.

Function
REQ-018 The FSM SHALL have three states: IDLE, BUS, RESP; req_ready=1 only in IDLE.
REQ-019 Accept = req_valid & req_ready; the unit SHALL register op, addr, data_i, wreg_en, and wreg_idx on accept.
REQ-020 An accepted NOP SHALL go IDLE->RESP, with wb_data=data_i and wb_en=wreg_en; latency 1 cycle.
REQ-021 An accepted aligned memory op SHALL go IDLE->BUS and hold bus_req=1 with stable bus_addr/be/we/wdata until bus_ack.
REQ-022 In BUS, bus_ack=1 SHALL capture bus_rdata and go to RESP next edge; minimum load latency accept->resp_valid is 2 cycles.
REQ-023 bus_be SHALL be 1<<addr[1:0] for a byte op, 4'b0011/4'b1100 for a half op selected by addr[1], and 4'b1111 for a word op.
REQ-024 SB SHALL replicate data_i[7:0] to all 4 lanes, SH SHALL replicate data_i[15:0] to both halves, and SW SHALL pass data_i unchanged.
REQ-025 Loads SHALL select the lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, and LW passes the word unchanged; lane mapping is little-endian.
REQ-026 Stores SHALL produce resp_valid=1 with wb_en=0.
REQ-027 A wait counter SHALL clear on BUS entry and increment each BUS cycle without ack; when it reaches TIMEOUT, bus_req SHALL drop and the FSM SHALL go to RESP with bus_err=1 and wb_en=0.
REQ-028 bus_ack on the same cycle the counter reaches TIMEOUT SHALL count as success (ack wins).
REQ-029 RESP SHALL last exactly 1 cycle with resp_valid=1 and then return to IDLE; back-to-back requests therefore issue at most one every 2 cycles.
REQ-030 bus_ack outside BUS SHALL be ignored.

Reset
REQ-031 rst=0 SHALL immediately force IDLE and clear the counter; all outputs SHALL be 0 except req_ready=1.
REQ-032 Reset during BUS SHALL drop bus_req in the same cycle and produce no resp_valid for the aborted op.

Configuration
REQ-033 LSU_MISALIGN_EXC_EN defined: a half op with addr[0]=1 or a word op with addr[1:0]!=0 SHALL skip BUS, go to RESP with exc_misalign=1, wb_en=0, and no bus_req.
REQ-034 LSU_MISALIGN_EXC_EN undefined: exc_misalign SHALL be tied 0, and a misaligned access SHALL be aligned down (half: addr[0] ignored; word: addr[1:0] ignored) and performed normally.

Verification
REQ-035 LB addr=0x1003, bus_rdata=0x80FF_1234, immediate ack -> wb_data=0xFFFF_FF80, wb_en=1, resp_valid 2 cycles after accept.
REQ-036 SH addr=0x2002, data_i=0x0000_BEEF -> bus_be=4'b1100, bus_wdata=0xBEEF_BEEF, bus_we=1; resp wb_en=0.
REQ-037 LW with no ack, TIMEOUT=4 -> bus_req high 4 cycles then low; resp_valid with bus_err=1, wb_en=0.
REQ-038 LH addr=0x0001: with macro -> exc_misalign=1 and no bus_req; without macro -> bus_be=4'b0011 and a normal load.
REQ-039 rst pulled low during BUS -> bus_req=0 same cycle, req_ready=1, and no resp_valid after release.
REQ-040 NOP data_i=0x1234_5678, wreg_idx=9, wreg_en=1 -> next cycle wb_data=0x1234_5678, wb_idx=9, with no bus activity.
